// File: rtl/adc_resp_pkg.sv
// adc_resp_pkg: shared state encoding and sizing constants for the ADC responder.
// Build option: ADC_RESP_LSBF_TAIL_EN adds the LSB-first tail state.
package adc_resp_pkg;

    localparam int DATA_W_DEFAULT = 12;
    localparam int CMD_BITS       = 3;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_START = 4'd1,
        ST_SGL   = 4'd2,
        ST_ODD   = 4'd3,
        ST_MSBF  = 4'd4,
        ST_NULL  = 4'd5,
        ST_DATA  = 4'd6,
        ST_DONE  = 4'd8
`ifdef ADC_RESP_LSBF_TAIL_EN
        , ST_TAIL = 4'd7
`endif
    } state_t;

endpackage

// File: rtl/adc_resp_shreg.sv
// adc_resp_shreg: loadable rotate-left result register; the serial output is the MSB,
// or the bit chosen by i_idx while the LSB-first tail is being read.
module adc_resp_shreg #(
    parameter int W  = 12,
    parameter int IW = 4
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_load,
    input  logic [W-1:0]  i_d,
    input  logic          i_shift,
    input  logic          i_sel_idx,
    input  logic [IW-1:0] i_idx,
    output logic          o_ser
);

    logic [W-1:0] r_q;

    // Rotating keeps the loaded word intact after W shifts so the tail can index it.
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) r_q <= '0;
        else if (i_load) r_q <= i_d;
        else if (i_shift) r_q <= {r_q[W-2:0], r_q[W-1]};

    assign o_ser = i_sel_idx ? r_q[i_idx] : r_q[W-1];

endmodule

// File: rtl/adc_spi_responder.sv
// adc_spi_responder: SPI model of a 12-bit two-channel SAR ADC (start/SGL/ODD/MSBF command,
// null bit, MSB-first result). Build option: ADC_RESP_LSBF_TAIL_EN appends an LSB-first tail when MSBF=0.
module adc_spi_responder
    import adc_resp_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              sck,
    input  logic              reset,
    input  logic              cs_n,
    input  logic              sdi,
    input  logic [DATA_W-1:0] ch0_sample,
    input  logic [DATA_W-1:0] ch1_sample,
    output logic              sdo,
    output logic              sdo_en,
    output logic              frame_done,
    output logic              cmd_sgl,
    output logic              cmd_odd,
    output logic              cmd_msbf
);

    localparam int CW = $clog2(DATA_W + 1);

    state_t            r_state, w_nxt;
    logic [CW-1:0]     r_cnt, w_cnt;
    logic              r_sgl, r_odd, r_cmd_sgl, r_cmd_odd, r_cmd_msbf;
    logic              r_sdo, r_sdo_en, r_done;
    logic              w_sdo, w_sdo_en, w_done, w_load, w_shift, w_ser, w_last, w_sel_idx;
    logic [CW-1:0]     w_idx;
    logic [DATA_W:0]   w_dif;
    logic [DATA_W-1:0] w_res;

    assign w_last = r_state == ST_DATA && r_cnt == CW'(DATA_W - 1);
    // The borrow bit of the widened subtraction selects the clamp to zero.
    assign w_dif  = r_odd ? {1'b0, ch1_sample} - {1'b0, ch0_sample}
                          : {1'b0, ch0_sample} - {1'b0, ch1_sample};
    assign w_res  = r_sgl ? (r_odd ? ch1_sample : ch0_sample)
                          : (w_dif[DATA_W] ? '0 : w_dif[DATA_W-1:0]);
`ifdef ADC_RESP_LSBF_TAIL_EN
    assign w_sel_idx = w_last || r_state == ST_TAIL;
    assign w_idx     = r_state == ST_TAIL ? r_cnt : CW'(1);
`else
    assign w_sel_idx = 1'b0;
    assign w_idx     = '0;
`endif

    adc_resp_shreg #(.W(DATA_W), .IW(CW)) u_shreg (
        .i_clk     (sck),
        .i_rst_n   (reset),
        .i_load    (w_load),
        .i_d       (w_res),
        .i_shift   (w_shift),
        .i_sel_idx (w_sel_idx),
        .i_idx     (w_idx),
        .o_ser     (w_ser)
    );

    // State register.
    always_ff @(posedge sck or negedge reset)
        if (!reset) r_state <= ST_IDLE;
        else r_state <= w_nxt;

    // Next state: deselect always returns to IDLE; DONE waits for deselect.
    always_comb begin
        w_nxt = r_state;
        if (cs_n) w_nxt = ST_IDLE;
        else
            case (r_state)
                ST_IDLE, ST_START: w_nxt = sdi ? ST_SGL : ST_START;
                ST_SGL:  w_nxt = ST_ODD;
                ST_ODD:  w_nxt = ST_MSBF;
                ST_MSBF: w_nxt = ST_NULL;
                ST_NULL: w_nxt = ST_DATA;
`ifdef ADC_RESP_LSBF_TAIL_EN
                ST_DATA: w_nxt = w_last ? (r_cmd_msbf ? ST_DONE : ST_TAIL) : ST_DATA;
                ST_TAIL: w_nxt = r_cnt == CW'(DATA_W) ? ST_DONE : ST_TAIL;
`else
                ST_DATA: w_nxt = w_last ? ST_DONE : ST_DATA;
`endif
                default: w_nxt = r_state;
            endcase
    end

    // Next values of the registered outputs, shift-register controls and bit counter.
    always_comb begin
        w_sdo    = 1'b0;
        w_sdo_en = 1'b0;
        w_done   = 1'b0;
        w_load   = 1'b0;
        w_shift  = 1'b0;
        w_cnt    = r_cnt;
        if (!cs_n)
            case (r_state)
                ST_MSBF: begin
                    w_sdo_en = 1'b1;
                    w_load   = 1'b1;
                end
                ST_NULL: begin
                    w_sdo_en = 1'b1;
                    w_sdo    = w_ser;
                    w_shift  = 1'b1;
                    w_cnt    = '0;
                end
                ST_DATA: begin
`ifdef ADC_RESP_LSBF_TAIL_EN
                    w_done   = w_last && r_cmd_msbf;
                    w_sdo_en = !w_done;
                    w_sdo    = !w_done && w_ser;
                    w_shift  = !w_last;
                    w_cnt    = w_last ? CW'(2) : r_cnt + CW'(1);
`else
                    w_done   = w_last;
                    w_sdo_en = !w_last;
                    w_sdo    = !w_last && w_ser;
                    w_shift  = !w_last;
                    w_cnt    = r_cnt + CW'(1);
`endif
                end
`ifdef ADC_RESP_LSBF_TAIL_EN
                ST_TAIL: begin
                    w_done   = r_cnt == CW'(DATA_W);
                    w_sdo_en = !w_done;
                    w_sdo    = !w_done && w_ser;
                    w_cnt    = r_cnt + CW'(1);
                end
`endif
                default: w_cnt = r_cnt;
            endcase
    end

    // Output, counter and command registers; commands publish only once MSBF is sampled.
    always_ff @(posedge sck or negedge reset)
        if (!reset) begin
            r_sdo      <= 1'b0;
            r_sdo_en   <= 1'b0;
            r_done     <= 1'b0;
            r_cnt      <= '0;
            r_sgl      <= 1'b0;
            r_odd      <= 1'b0;
            r_cmd_sgl  <= 1'b0;
            r_cmd_odd  <= 1'b0;
            r_cmd_msbf <= 1'b0;
        end else begin
            r_sdo    <= w_sdo;
            r_sdo_en <= w_sdo_en;
            r_done   <= w_done;
            r_cnt    <= w_cnt;
            if (!cs_n && r_state == ST_SGL) r_sgl <= sdi;
            if (!cs_n && r_state == ST_ODD) r_odd <= sdi;
            if (!cs_n && r_state == ST_MSBF) begin
                r_cmd_sgl  <= r_sgl;
                r_cmd_odd  <= r_odd;
                r_cmd_msbf <= sdi;
            end
        end

    assign sdo        = r_sdo;
    assign sdo_en     = r_sdo_en;
    assign frame_done = r_done;
    assign cmd_sgl    = r_cmd_sgl;
    assign cmd_odd    = r_cmd_odd;
    assign cmd_msbf   = r_cmd_msbf;

endmodule
